hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Hazard-resolution block for the five-stage pipelined MIPS core.
- Receives register indices and stage control flags from the datapath.
- Returns the stall, flush and forward-select signals the datapath consumes.
- Adds registered stall-cause tracking, a stuck-pipeline watchdog and optional performance counters, so the bench and the FPGA debug logic can see hazard activity.

Parameters:
- MAX_STALL, 2, maximum legal number of consecutive stall cycles before hazard_err_o is raised.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i in 1 clock
- reset_i in 1 reset, asynchronous, active-high
- branch_d_i in 1 decode-stage instruction is a branch
- rs_d_i in 5 rs field, decode stage
- rt_d_i in 5 rt field, decode stage
- rs_e_i in 5 rs field, execute stage
- rt_e_i in 5 rt field, execute stage
- writerf_e_i in 5 destination register, execute stage
- writerf_m_i in 5 destination register, memory stage
- writerf_w_i in 5 destination register, writeback stage
- memtorf_e_i in 1 execute-stage instruction is a load
- rfwrite_e_i in 1 execute-stage instruction writes the register file
- memtorf_m_i in 1 memory-stage instruction is a load
- rfwrite_m_i in 1 memory-stage instruction writes the register file
- rfwrite_w_i in 1 writeback-stage instruction writes the register file
- err_clr_i in 1 synchronous clear of hazard_err_o
- stall_f_o out 1 hold PC
- stall_d_o out 1 hold the F/D register
- flush_e_o out 1 bubble into the D/E register
- forwardad_o out 1 decode operand A takes ALU output from memory stage
- forwardbd_o out 1 decode operand B takes ALU output from memory stage
- forwardae_o out 2 execute operand A select: 00 register file, 01 result_w, 10 aluout_m
- forwardbe_o out 2 execute operand B select, same encoding
- stall_state_o out 2 registered stall cause: 00 RUN, 01 LU_STALL, 10 BR_STALL
- hazard_err_o out 1 sticky watchdog error
- lw_stall_cnt_o out CNT_W load-use stall cycles
- br_stall_cnt_o out CNT_W branch stall cycles
- fwd_cnt_o out CNT_W cycles in which any forward select is nonzero

Behaviour:
Combinational path (zero latency):
- forwardae_o = 10 if rs_e != 0, rs_e == writerf_m and rfwrite_m.
- Otherwise forwardae_o = 01 if rs_e != 0, rs_e == writerf_w and rfwrite_w.
- Otherwise forwardae_o = 00. The memory-stage match has priority over writeback.
- forwardbe_o follows the same rules using rt_e.
- forwardad_o = (rs_d != 0) & (rs_d == writerf_m) & rfwrite_m. forwardbd_o uses rt_d the same way.
- lwstall = memtorf_e & ((rt_e == rs_d) | (rt_e == rt_d)).
- branchstall = branch_d & ((rfwrite_e & (writerf_e == rs_d | writerf_e == rt_d)) | (memtorf_m & (writerf_m == rs_d | writerf_m == rt_d))).
- stall_f_o = stall_d_o = flush_e_o = lwstall | branchstall.
- All combinational outputs are valid from reset; they carry no reset values.

Stall-cause FSM:
- Updates on the clock edge.
- Next state is LU_STALL if lwstall; otherwise BR_STALL if branchstall; otherwise RUN.
- When both causes are present, LU_STALL wins.
- Reset state is RUN. Encoding 11 is unreachable and recovers to RUN on the next clock.

Watchdog:
- run counter: increments while stall is asserted and clears to 0 when stall is deasserted.
- It saturates at MAX_STALL+1.
- hazard_err_o sets on the edge where stall is asserted and run == MAX_STALL; it then stays set.
- err_clr_i clears hazard_err_o. If set and clear occur in the same cycle, set wins.
- Reset values: run = 0, hazard_err_o = 0.
- Asserting reset mid-stall clears run, the FSM state and the error immediately (asynchronous).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - The three counters are registered, reset to 0 and increment by 1 per qualifying cycle.
  - A cycle with both lwstall and branchstall counts in lw_stall_cnt_o only.
  - Counters saturate at all ones and never wrap.
  - err_clr_i also zeroes all three counters.
- Undefined: lw_stall_cnt_o, br_stall_cnt_o and fwd_cnt_o are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package mips_pkg holds:
  - the stall_state_t enum (RUN, LU_STALL, BR_STALL);
  - the forward-select localparams FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - REG_ZERO = 5'd0.
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr), instantiated three times under the macro.

Test Plan:
- add $3 in M (rfwrite_m = 1, writerf_m = 3) with rs_e = 3 -> forwardae_o = 10. Same case with writerf_m = 0 and rs_e = 0 -> forwardae_o = 00.
- rs_e = 5 matching both M and W (rfwrite_m = rfwrite_w = 1) -> forwardae_o = 10. Drop rfwrite_m -> forwardae_o = 01.
- lw $2 in E (memtorf_e = 1, rt_e = 2) with rs_d = 2 -> stall_f/stall_d/flush_e = 1 for one cycle. Next cycle stall_state_o = 01, lw_stall_cnt_o = 1.
- lw $4 followed by beq $4,$0 -> cycle 1 has lwstall and branchstall, cycle 2 has branchstall via memtorf_m. Stall lasts 2 cycles, stall_state_o goes 01 then 10, hazard_err_o stays 0.
- Hold lwstall high for 3 cycles with MAX_STALL = 2 -> hazard_err_o = 1 after the 3rd edge. Assert err_clr_i for 1 cycle with no stall -> hazard_err_o = 0 and counters = 0.
- Assert reset_i asynchronously mid-stall -> stall_state_o = 00, hazard_err_o = 0 and counters = 0 before the next clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the five-stage MIPS core.
// Stall-cause encoding, forward-select codes and a forward-select helper.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        BR_STALL = 2'b10
    } stall_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Memory-stage producer beats writeback; $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       wr_m,
        input logic [4:0] dst_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != REG_ZERO) begin
            if (wr_m && (src == dst_m)) begin
                sel = FWD_MEM;
            end else if (wr_w && (src == dst_w)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear beats increment; the count sticks at all ones.
module sat_counter
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard resolution for the five-stage MIPS pipeline: forwarding, stalls,
// stall-cause tracking and watchdog. Counters under HAZARD_PERF_CNT_EN.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MAX_STALL = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             branch_d_i,
    input  logic [4:0]       rs_d_i,
    input  logic [4:0]       rt_d_i,
    input  logic [4:0]       rs_e_i,
    input  logic [4:0]       rt_e_i,
    input  logic [4:0]       writerf_e_i,
    input  logic [4:0]       writerf_m_i,
    input  logic [4:0]       writerf_w_i,
    input  logic             memtorf_e_i,
    input  logic             rfwrite_e_i,
    input  logic             memtorf_m_i,
    input  logic             rfwrite_m_i,
    input  logic             rfwrite_w_i,
    input  logic             err_clr_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_e_o,
    output logic             forwardad_o,
    output logic             forwardbd_o,
    output logic [1:0]       forwardae_o,
    output logic [1:0]       forwardbe_o,
    output logic [1:0]       stall_state_o,
    output logic             hazard_err_o,
    output logic [CNT_W-1:0] lw_stall_cnt_o,
    output logic [CNT_W-1:0] br_stall_cnt_o,
    output logic [CNT_W-1:0] fwd_cnt_o
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

    logic         lwstall;
    logic         branchstall;
    logic         stall;
    logic         br_src_e;
    logic         br_src_m;

    stall_state_t state_q;
    stall_state_t state_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic         err_q;
    logic         err_d;

    // Forward selects and stall detection.
    always_comb begin
        forwardae_o = fwd_sel(rs_e_i, writerf_m_i, rfwrite_m_i,
                              writerf_w_i, rfwrite_w_i);
        forwardbe_o = fwd_sel(rt_e_i, writerf_m_i, rfwrite_m_i,
                              writerf_w_i, rfwrite_w_i);
        forwardad_o = (rs_d_i != REG_ZERO) && (rs_d_i == writerf_m_i)
                      && rfwrite_m_i;
        forwardbd_o = (rt_d_i != REG_ZERO) && (rt_d_i == writerf_m_i)
                      && rfwrite_m_i;
        lwstall     = memtorf_e_i
                      && ((rt_e_i == rs_d_i) || (rt_e_i == rt_d_i));
        br_src_e    = rfwrite_e_i
                      && ((writerf_e_i == rs_d_i) || (writerf_e_i == rt_d_i));
        br_src_m    = memtorf_m_i
                      && ((writerf_m_i == rs_d_i) || (writerf_m_i == rt_d_i));
        branchstall = branch_d_i && (br_src_e || br_src_m);
        stall       = lwstall || branchstall;
    end

    assign stall_f_o = stall;
    assign stall_d_o = stall;
    assign flush_e_o = stall;

    // Stall cause for next cycle; load-use outranks branch, 11 falls to RUN.
    always_comb begin
        state_d = RUN;
        if (lwstall) begin
            state_d = LU_STALL;
        end else if (branchstall) begin
            state_d = BR_STALL;
        end
    end

    // Watchdog run length and sticky error; a fresh set beats a clear.
    always_comb begin
        run_d = '0;
        err_d = err_q;
        if (stall) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;
        end
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (stall && (run_q == RUN_MAX)) begin
            err_d = 1'b1;
        end
    end

    // State, run counter and error registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RUN;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign stall_state_o = state_q;
    assign hazard_err_o  = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic any_fwd;

    assign any_fwd = forwardad_o || forwardbd_o
                     || (forwardae_o != FWD_RF)
                     || (forwardbe_o != FWD_RF);

    sat_counter #(.W(CNT_W)) u_lw_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (lwstall),
        .clr_i   (err_clr_i),
        .cnt_o   (lw_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (branchstall && !lwstall),
        .clr_i   (err_clr_i),
        .cnt_o   (br_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_fwd_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (any_fwd),
        .clr_i   (err_clr_i),
        .cnt_o   (fwd_cnt_o)
    );
`else
    assign lw_stall_cnt_o = '0;
    assign br_stall_cnt_o = '0;
    assign fwd_cnt_o      = '0;
`endif

endmodule
